// File: rtl/ipsl_hmic_h_ddrc_apb_user_master_v1_1.sv
// ----------------------------------------------------------------------------
// ipsl_hmic_h_ddrc_apb_user_master_v1_1
// Queues register-access commands from a user client and replays them, one at
// a time, as APB transfers on the user APB side of the DDRC reset controller.
// Issue is held off until the controller reports init complete. An ACCESS phase
// that sees no pready for TIMEOUT cycles is aborted and reported as an error.
//
// Ports
//   pclk, preset          : clock, synchronous active-high reset
//   ddr_init_done         : gates popping of new commands (never aborts one)
//   cmd_valid/cmd_ready   : command handshake (ready = FIFO not full)
//   cmd_write/addr/wdata  : command payload
//   rsp_valid/rsp_ready   : response handshake, held until consumed
//   rsp_rdata/rsp_err     : read data (0 for writes/timeouts), timeout flag
//   user_psel/penable/pwrite/paddr/pwdata : APB requester outputs
//   ddrc_prdata/pready    : APB completer response
//   busy                  : FIFO non-empty or transfer in flight
// ----------------------------------------------------------------------------
module ipsl_hmic_h_ddrc_apb_user_master_v1_1 #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  TIMEOUT    = 8'd255
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        ddr_init_done,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [11:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        user_psel,
  output logic        user_penable,
  output logic        user_pwrite,
  output logic [11:0] user_paddr,
  output logic [31:0] user_pwdata,
  input  logic [31:0] ddrc_prdata,
  input  logic        ddrc_pready,
  output logic        busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 1 + 12 + 32;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  // Counter value seen during the last permitted ACCESS cycle
  localparam logic [7:0]    TO_LAST = 8'(TIMEOUT - 8'd1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Command FIFO storage and bookkeeping
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          r_cmd_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;

  // Transfer control
  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_tcnt;
  logic          w_tmo;

  // Registered outputs
  logic          r_busy;
  logic          r_psel;
  logic          r_penable;
  logic          r_pwrite;
  logic [11:0]   r_paddr;
  logic [31:0]   r_pwdata;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_rdata;
  logic          r_rsp_err;

  assign w_empty = (r_count == '0);
  // r_cmd_ready always mirrors "count != depth", so it doubles as the full flag
  assign w_push  = cmd_valid && r_cmd_ready;

  // Occupancy update; simultaneous push and pop leave it unchanged
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO payload array (no reset needed: entries are only read when valid)
  always_ff @(posedge pclk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {cmd_write, cmd_addr, cmd_wdata};
    end
  end

  // FSM state register
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state; pready in the expiry cycle wins over the timeout
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && ddr_init_done) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (ddrc_pready) begin
          w_state_nxt = S_RESP;
        end else if (r_tcnt == TO_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath, FIFO pointers and output registers (driven from next state so
  // psel/penable come straight off flops)
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_tcnt      <= 8'd0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= 12'd0;
      r_pwdata    <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
        {r_pwrite, r_paddr, r_pwdata} <= r_mem[r_rptr];
      end
      r_count     <= w_count_nxt;
      r_cmd_ready <= (w_count_nxt != DEPTH_C);
      r_busy      <= (w_count_nxt != '0) || (w_state_nxt != S_IDLE);
      r_psel      <= (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
      r_penable   <= (w_state_nxt == S_ACCESS);
      r_rsp_valid <= (w_state_nxt == S_RESP);

      // Counts ACCESS cycles of the current transfer only
      if (r_state == S_ACCESS) begin
        r_tcnt <= r_tcnt + 8'd1;
      end else begin
        r_tcnt <= 8'd0;
      end

      // Response captured on the ACCESS -> RESP transition, then held
      if ((r_state == S_ACCESS) && (w_state_nxt == S_RESP)) begin
        r_rsp_err   <= w_tmo;
        r_rsp_rdata <= (ddrc_pready && !r_pwrite) ? ddrc_prdata : 32'd0;
      end
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign busy         = r_busy;
  assign user_psel    = r_psel;
  assign user_penable = r_penable;
  assign user_pwrite  = r_pwrite;
  assign user_paddr   = r_paddr;
  assign user_pwdata  = r_pwdata;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_err      = r_rsp_err;

endmodule

// File: doc/ipsl_hmic_h_ddrc_apb_user_master_v1_1.md
IPSL_HMIC_H_DDRC_APB_USER_MASTER_V1_1 -- requirements
Module: ipsl_hmic_h_ddrc_apb_user_master_v1_1

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO depth (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 8'd255, maximum ACCESS-phase cycles before abort (1..255).
REQ-003 SHALL have port pclk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port preset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port ddr_init_done, input, 1 bit: controller init complete; gates APB issue.
REQ-006 SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-007 SHALL have port cmd_ready, output, 1 bit: command FIFO not full.
REQ-008 SHALL have port cmd_write, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port cmd_addr, input, 12 bits: APB register address.
REQ-010 SHALL have port cmd_wdata, input, 32 bits: write data.
REQ-011 SHALL have port rsp_valid, output, 1 bit: response held.
REQ-012 SHALL have port rsp_ready, input, 1 bit: response consumed.
REQ-013 SHALL have port rsp_rdata, output, 32 bits: read data (0 for writes and timeouts).
REQ-014 SHALL have port rsp_err, output, 1 bit: transaction aborted on timeout.
REQ-015 SHALL have ports user_psel, user_penable, user_pwrite (1 bit each), user_paddr (12 bits), user_pwdata (32 bits): outputs to the DDRC reset controller's user APB side.
REQ-016 SHALL have ports ddrc_prdata, input, 32 bits, and ddrc_pready, input, 1 bit: APB completer response.
REQ-017 SHALL have port busy, output, 1 bit: FIFO non-empty or FSM not IDLE.

Function
REQ-018 SHALL accept a command on a rising edge where cmd_valid && cmd_ready; cmd_ready = !fifo_full, combinationally independent of cmd_valid.
REQ-019 SHALL push and pop in the same cycle without changing occupancy; read/write pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-020 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-021 IDLE->SETUP (with pop) only when FIFO non-empty and ddr_init_done=1; otherwise remain in IDLE.
REQ-022 SETUP: user_psel=1, user_penable=0, address/pwrite/pwdata driven from the popped entry; exactly one cycle, then ACCESS.
REQ-023 ACCESS: user_psel=1, user_penable=1, address/data held stable; timeout counter increments each ACCESS cycle.
REQ-024 ACCESS with ddrc_pready=1: capture ddrc_prdata into rsp_rdata if read (0 if write), rsp_err=0, -> RESP.
REQ-025 ACCESS with pready=0 for TIMEOUT consecutive cycles: rsp_err=1, rsp_rdata=0, -> RESP; pready arriving in the same cycle as expiry SHALL take priority (normal completion).
REQ-026 RESP: user_psel=user_penable=0, rsp_valid=1, rsp_rdata/rsp_err stable; -> IDLE on rsp_ready=1.
REQ-027 Latency: command accepted into an empty FIFO at edge N with ddr_init_done=1 -> user_psel high in the cycle after edge N+1; pready in first ACCESS cycle -> rsp_valid high the next cycle.
REQ-028 ddr_init_done falling mid-transaction SHALL NOT abort it; the current transaction completes, no further pop occurs until it returns high.
REQ-029 Outputs user_pwrite/user_paddr/user_pwdata SHALL hold last value outside SETUP/ACCESS; user_psel/penable SHALL be registered, glitch-free.

Reset
REQ-030 On preset=1 at an edge: FSM=IDLE, FIFO empty, cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, user_psel=0, user_penable=0, user_pwrite=0, user_paddr=0, user_pwdata=0, busy=0, timeout counter=0.
REQ-031 preset mid-transaction SHALL drop user_psel/penable at that edge and discard queued commands and pending response.

Verification
REQ-032 ddr_init_done=0, push 4 commands -> cmd_ready=0 after 4th, no psel; raise init_done -> 4 transactions issued in FIFO order.
REQ-033 Read addr 12'h0C4, pready=1 after 3 ACCESS cycles, prdata 32'hDEAD_BEEF -> rsp_rdata=32'hDEAD_BEEF, rsp_err=0, penable high exactly 3 cycles.
REQ-034 Write with pready stuck 0, TIMEOUT=8 -> ACCESS lasts 8 cycles, rsp_err=1, rsp_rdata=0.
REQ-035 rsp_ready held 0 for 10 cycles with FIFO non-empty -> no new SETUP until response consumed; rsp outputs stable.
REQ-036 preset asserted during ACCESS with 2 queued -> next cycle psel=0, busy=0, cmd_ready=1, no response emitted.
REQ-037 Push and pop same cycle at FIFO occupancy 3 -> occupancy stays 3, cmd_ready stays 1.
